// File: rtl/execute_stage.sv
// execute_stage: Execute stage of the 19-bit pipe, feeding Memory.
// Operand forwarding, ALU (iterative multiply), Execute/Memory register.
// Ports: clk, reset (sync, active high); E-side control, operands,
//   forwarding selects, ResultW, FlushE in; registered M-side control,
//   RdM, WriteDataM, ALUResultM and combinational StallE out.
// Option: EXEC_MUL_EN compiles in the shift-add multiply FSM; when
//   undefined, op 110 is single-cycle with result 0 and StallE is 0.
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        Cant_ByteE,
  input  logic [2:0]  ALUControlE,
  input  logic        ALUSrcE,
  input  logic [18:0] RD1E,
  input  logic [18:0] RD2E,
  input  logic [18:0] ImmExtE,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [18:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic        Cant_ByteM,
  output logic [4:0]  RdM,
  output logic [18:0] WriteDataM,
  output logic [18:0] ALUResultM,
  output logic        StallE
);

  typedef enum logic [1:0] {
    LD_INSTR,
    LD_BUBBLE,
    LD_MUL
  } ld_e;

  logic [18:0] src_a;
  logic [18:0] fwd_b;
  logic [18:0] src_b;
  logic [18:0] alu_y;
  logic [4:0]  shamt;
  logic        big_sh;
  ld_e         ld_sel;

  always_comb begin
    unique case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    unique case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
    src_b = ALUSrcE ? ImmExtE : fwd_b;
  end

  assign shamt  = src_b[4:0];
  assign big_sh = (shamt >= 5'd19);

  // op 110 yields 0 here; the multiply result comes from the FSM
  always_comb begin
    alu_y = '0;
    unique case (ALUControlE)
      3'b000: alu_y = src_a + src_b;
      3'b001: alu_y = src_a - src_b;
      3'b010: alu_y = src_a & src_b;
      3'b011: alu_y = src_a | src_b;
      3'b100: alu_y = big_sh ? '0 : (src_a << shamt);
      3'b101: alu_y = big_sh ? '0 : (src_a >> shamt);
      3'b111: alu_y = {18'd0, $signed(src_a) < $signed(src_b)};
      default: alu_y = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        start;
  logic [18:0] mc_a;
  logic [18:0] mc_b;
  logic [18:0] acc;
  logic [4:0]  cnt;
  logic        lt_rw;
  logic        lt_mw;
  logic        lt_rs;
  logic        lt_cb;
  logic [4:0]  lt_rd;
  logic [18:0] lt_wd;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // flush beats a mul issue; flush is ignored once the mul is running
  always_comb begin
    state_n = state;
    StallE  = 1'b0;
    ld_sel  = LD_INSTR;
    start   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (FlushE) begin
          ld_sel = LD_BUBBLE;
        end else if (ALUControlE == 3'b110) begin
          ld_sel  = LD_BUBBLE;
          StallE  = 1'b1;
          start   = 1'b1;
          state_n = S_MUL;
        end
      end
      S_MUL: begin
        ld_sel = LD_BUBBLE;
        StallE = 1'b1;
        if (cnt == 5'd18) state_n = S_DONE;
      end
      S_DONE: begin
        ld_sel  = LD_MUL;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // one shift-add step per cycle over all 19 multiplier bits
  always_ff @(posedge clk) begin
    if (reset) begin
      mc_a  <= '0;
      mc_b  <= '0;
      acc   <= '0;
      cnt   <= '0;
      lt_rw <= 1'b0;
      lt_mw <= 1'b0;
      lt_rs <= 1'b0;
      lt_cb <= 1'b0;
      lt_rd <= '0;
      lt_wd <= '0;
    end else if (start) begin
      mc_a  <= src_a;
      mc_b  <= src_b;
      acc   <= '0;
      cnt   <= '0;
      lt_rw <= RegWriteE;
      lt_mw <= MemWriteE;
      lt_rs <= ResultSrcE;
      lt_cb <= Cant_ByteE;
      lt_rd <= RdE;
      lt_wd <= fwd_b;
    end else if (state == S_MUL) begin
      if (mc_b[0]) acc <= acc + mc_a;
      mc_a <= mc_a << 1;
      mc_b <= mc_b >> 1;
      cnt  <= cnt + 5'd1;
    end
  end
`else
  assign StallE = 1'b0;

  always_comb begin
    ld_sel = FlushE ? LD_BUBBLE : LD_INSTR;
  end
`endif

  // bubbles clear control but keep the data fields unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      Cant_ByteM <= 1'b0;
      RdM        <= '0;
      WriteDataM <= '0;
      ALUResultM <= '0;
    end else begin
      unique case (ld_sel)
        LD_INSTR: begin
          RegWriteM  <= RegWriteE;
          MemWriteM  <= MemWriteE;
          ResultSrcM <= ResultSrcE;
          Cant_ByteM <= Cant_ByteE;
          RdM        <= RdE;
          WriteDataM <= fwd_b;
          ALUResultM <= alu_y;
        end
`ifdef EXEC_MUL_EN
        LD_MUL: begin
          RegWriteM  <= lt_rw;
          MemWriteM  <= lt_mw;
          ResultSrcM <= lt_rs;
          Cant_ByteM <= lt_cb;
          RdM        <= lt_rd;
          WriteDataM <= lt_wd;
          ALUResultM <= acc;
        end
`endif
        default: begin
          RegWriteM  <= 1'b0;
          MemWriteM  <= 1'b0;
          ResultSrcM <= 1'b0;
          Cant_ByteM <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: scoreboard bench for execute_stage.
// Stimulus queues expected M outputs / StallE by cycle; a monitor checks.
module tb_execute_stage;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] SLL = 3'b100;
  localparam logic [2:0] SRL = 3'b101;
  localparam logic [2:0] MUL = 3'b110;
  localparam logic [2:0] SLT = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, MemWriteE, ResultSrcE, Cant_ByteE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE;
  logic [18:0] RD1E, RD2E, ImmExtE;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [18:0] ResultW;
  logic        FlushE;
  logic        RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM;
  logic [4:0]  RdM;
  logic [18:0] WriteDataM, ALUResultM;
  logic        StallE;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .Cant_ByteE(Cant_ByteE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .Cant_ByteM(Cant_ByteM),
    .RdM(RdM), .WriteDataM(WriteDataM), .ALUResultM(ALUResultM),
    .StallE(StallE)
  );

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic        rw, mw, rs, cb;
    logic [4:0]  rd;
    logic [18:0] wd, alu;
    logic        st;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic exp_m(input int c, input logic rw, input logic mw,
                       input logic rs, input logic cb,
                       input logic [4:0] rd, input logic [18:0] wd,
                       input logic [18:0] alu, input string n);
    exp_t e;
    e.cyc = c; e.kind = 0;
    e.rw = rw; e.mw = mw; e.rs = rs; e.cb = cb;
    e.rd = rd; e.wd = wd; e.alu = alu; e.st = 1'b0; e.name = n;
    sb.push_back(e);
  endtask

  task automatic exp_ctl0(input int c, input string n);
    exp_t e;
    e.cyc = c; e.kind = 1;
    e.rw = 0; e.mw = 0; e.rs = 0; e.cb = 0;
    e.rd = '0; e.wd = '0; e.alu = '0; e.st = 1'b0; e.name = n;
    sb.push_back(e);
  endtask

  task automatic exp_st(input int c, input logic s, input string n);
    exp_t e;
    e.cyc = c; e.kind = 2;
    e.rw = 0; e.mw = 0; e.rs = 0; e.cb = 0;
    e.rd = '0; e.wd = '0; e.alu = '0; e.st = s; e.name = n;
    sb.push_back(e);
  endtask

  // monitor: compare every queued expectation due this cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc) begin
          failures++;
          $display("FAIL %s: expectation for cycle %0d never checked",
                   sb[i].name, sb[i].cyc);
        end else if (sb[i].kind == 0) begin
          if ({RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM, RdM,
               WriteDataM, ALUResultM} !==
              {sb[i].rw, sb[i].mw, sb[i].rs, sb[i].cb, sb[i].rd,
               sb[i].wd, sb[i].alu}) begin
            failures++;
            $display("FAIL %s cyc=%0d got ctl=%b%b%b%b rd=%0d wd=%h alu=%h exp ctl=%b%b%b%b rd=%0d wd=%h alu=%h",
                     sb[i].name, cyc, RegWriteM, MemWriteM, ResultSrcM,
                     Cant_ByteM, RdM, WriteDataM, ALUResultM,
                     sb[i].rw, sb[i].mw, sb[i].rs, sb[i].cb, sb[i].rd,
                     sb[i].wd, sb[i].alu);
          end
        end else if (sb[i].kind == 1) begin
          if ({RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM} !== 4'b0) begin
            failures++;
            $display("FAIL %s cyc=%0d bubble ctl got %b%b%b%b exp 0000",
                     sb[i].name, cyc, RegWriteM, MemWriteM, ResultSrcM,
                     Cant_ByteM);
          end
        end else begin
          if (StallE !== sb[i].st) begin
            failures++;
            $display("FAIL %s cyc=%0d StallE got %b exp %b",
                     sb[i].name, cyc, StallE, sb[i].st);
          end
        end
        sb.delete(i);
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic rw,
                       input logic mw, input logic rs, input logic cb,
                       input logic src, input logic [18:0] a,
                       input logic [18:0] b, input logic [18:0] imm,
                       input logic [4:0] rd, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [18:0] resw,
                       input logic fl);
    ALUControlE = op; RegWriteE = rw; MemWriteE = mw;
    ResultSrcE = rs; Cant_ByteE = cb; ALUSrcE = src;
    RD1E = a; RD2E = b; ImmExtE = imm; RdE = rd;
    ForwardAE = fa; ForwardBE = fb; ResultW = resw; FlushE = fl;
  endtask

  task automatic idle();
    drive(ADD, 0, 0, 0, 0, 0, 19'd0, 19'd0, 19'd0, 5'd0, 2'b00, 2'b00,
          19'd0, 0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // issues a mul at the current cycle and holds it until accepted
  task automatic mul_op(input logic [18:0] a, input logic [18:0] b,
                        input logic [18:0] imm, input logic src,
                        input logic [4:0] rd, input logic [18:0] wd,
                        input logic [18:0] prod, input int flush_at,
                        input string n);
    int c;
    c = cyc;
    drive(MUL, 1, 0, 0, 0, src, a, b, imm, rd, 2'b00, 2'b00, 19'd0, 0);
`ifdef EXEC_MUL_EN
    for (int i = 0; i <= 20; i++) exp_st(c + i, (i < 20), n);
    for (int i = 1; i <= 20; i++) exp_ctl0(c + i, n);
    exp_m(c + 21, 1, 0, 0, 0, rd, wd, prod, n);
    for (int i = 1; i <= 21; i++) begin
      next();
      FlushE = (i == flush_at);
    end
`else
    exp_st(c, 0, n);
    exp_m(c + 1, 1, 0, 0, 0, rd, wd, 19'd0, n);
    next();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1;
    idle();
    next();
    next();
    exp_m(cyc, 0, 0, 0, 0, 5'd0, 19'd0, 19'd0, "reset_state");
    exp_st(cyc, 0, "reset_stall");
    reset = 1'b0;

    drive(ADD, 1, 0, 0, 0, 0, 19'h7FFFF, 19'd1, 19'd0, 5'd5, 0, 0, 0, 0);
    exp_m(cyc + 1, 1, 0, 0, 0, 5'd5, 19'd1, 19'd0, "add_wrap");
    next();
    drive(SLT, 1, 0, 0, 1, 0, 19'h7FFFF, 19'd1, 19'd0, 5'd6, 0, 0, 0, 0);
    exp_m(cyc + 1, 1, 0, 0, 1, 5'd6, 19'd1, 19'd1, "slt_neg");
    next();
    drive(ADD, 1, 0, 0, 0, 1, 19'd7, 19'd9, 19'd3, 5'd7, 2'b01, 0,
          19'd100, 0);
    exp_m(cyc + 1, 1, 0, 0, 0, 5'd7, 19'd9, 19'd103, "fwd_a_w");
    next();
    drive(ADD, 0, 1, 0, 0, 1, 19'd10, 19'd55, 19'd4, 5'd0, 0, 2'b10,
          19'd0, 0);
    exp_m(cyc + 1, 0, 1, 0, 0, 5'd0, 19'd103, 19'd14, "fwd_b_m_store");
    next();
    drive(SLL, 1, 0, 0, 0, 1, 19'd1, 19'd0, 19'd18, 5'd8, 0, 0, 0, 0);
    exp_m(cyc + 1, 1, 0, 0, 0, 5'd8, 19'd0, 19'h40000, "sll_18");
    next();
    drive(SLL, 1, 0, 0, 0, 1, 19'd1, 19'd0, 19'd19, 5'd9, 0, 0, 0, 0);
    exp_m(cyc + 1, 1, 0, 0, 0, 5'd9, 19'd0, 19'd0, "sll_19");
    next();
    drive(SRL, 1, 0, 0, 0, 0, 19'h40000, 19'd18, 19'd0, 5'd10, 0, 0, 0, 0);
    exp_m(cyc + 1, 1, 0, 0, 0, 5'd10, 19'd18, 19'd1, "srl_18");
    next();
    drive(SRL, 1, 0, 0, 0, 1, 19'h7FFFF, 19'd0, 19'd4, 5'd11, 0, 0, 0, 0);
    exp_m(cyc + 1, 1, 0, 0, 0, 5'd11, 19'd0, 19'h07FFF, "srl_logical");
    next();
    drive(SUB, 1, 0, 1, 0, 0, 19'd5, 19'd7, 19'd0, 5'd12, 0, 0, 0, 0);
    exp_m(cyc + 1, 1, 0, 1, 0, 5'd12, 19'd7, 19'h7FFFE, "sub_borrow");
    next();
    drive(AND, 1, 0, 0, 0, 0, 19'h5A5A5, 19'h0FF0F, 19'd0, 5'd13, 2'b11,
          0, 19'd1, 0);
    exp_m(cyc + 1, 1, 0, 0, 0, 5'd13, 19'h0FF0F, 19'h0A505, "and_fwd11");
    next();
    drive(OR, 1, 0, 0, 0, 0, 19'h5A5A5, 19'd0, 19'd0, 5'd14, 0, 2'b01,
          19'h0FF0F, 0);
    exp_m(cyc + 1, 1, 0, 0, 0, 5'd14, 19'h0FF0F, 19'h5FFAF, "or_fwd_b_w");
    next();
    drive(ADD, 1, 1, 1, 1, 0, 19'd1, 19'd1, 19'd0, 5'd15, 0, 0, 0, 1);
    exp_m(cyc + 1, 0, 0, 0, 0, 5'd14, 19'h0FF0F, 19'h5FFAF, "flush_hold");
    next();
    drive(SLL, 1, 0, 0, 0, 0, 19'd3, 19'h00021, 19'd0, 5'd16, 0, 0, 0, 0);
    exp_m(cyc + 1, 1, 0, 0, 0, 5'd16, 19'h00021, 19'd6, "sll_low5");
    next();
    drive(SLT, 1, 0, 0, 0, 0, 19'd1, 19'h7FFFF, 19'd0, 5'd17, 0, 0, 0, 0);
    exp_m(cyc + 1, 1, 0, 0, 0, 5'd17, 19'h7FFFF, 19'd0, "slt_pos_neg");
    next();

    c = cyc;
    drive(ADD, 1, 0, 0, 0, 0, 19'd3, 19'd4, 19'd0, 5'd9, 0, 0, 0, 0);
    reset = 1'b1;
    exp_st(c, 0, "midreset_stall");
    exp_m(c + 1, 0, 0, 0, 0, 5'd0, 19'd0, 19'd0, "midreset_1");
    exp_m(c + 2, 0, 0, 0, 0, 5'd0, 19'd0, 19'd0, "midreset_2");
    next();
    next();
    reset = 1'b0;

    mul_op(19'd300, 19'd500, 19'd0, 0, 5'd20, 19'd500, 19'd150000, -1,
           "mul_300x500");
    mul_op(19'd1000, 19'd7, 19'd1000, 1, 5'd21, 19'd7, 19'd475712, -1,
           "mul_1000x1000");

    drive(MUL, 1, 0, 0, 0, 0, 19'd2, 19'd3, 19'd0, 5'd22, 0, 0, 0, 1);
    exp_st(cyc, 0, "flush_mul_stall");
`ifdef EXEC_MUL_EN
    exp_m(cyc + 1, 0, 0, 0, 0, 5'd21, 19'd7, 19'd475712, "flush_mul");
`else
    exp_m(cyc + 1, 0, 0, 0, 0, 5'd21, 19'd7, 19'd0, "flush_mul");
`endif
    next();

`ifdef EXEC_MUL_EN
    mul_op(19'd12, 19'd13, 19'd0, 0, 5'd23, 19'd13, 19'd156, 5,
           "mul_flush_ignored");
    drive(ADD, 1, 0, 0, 0, 0, 19'd2, 19'd3, 19'd0, 5'd3, 0, 0, 0, 0);
    exp_m(cyc + 1, 1, 0, 0, 0, 5'd3, 19'd3, 19'd5, "after_mul_accept");
    next();

    c = cyc;
    drive(MUL, 1, 0, 0, 0, 0, 19'd300, 19'd500, 19'd0, 5'd24, 0, 0, 0, 0);
    for (int i = 0; i <= 10; i++) exp_st(c + i, 1, "abort_stall");
    for (int i = 1; i <= 10; i++) exp_ctl0(c + i, "abort_bubble");
    repeat (10) next();
    reset = 1'b1;
    idle();
    next();
    reset = 1'b0;
    exp_m(c + 11, 0, 0, 0, 0, 5'd0, 19'd0, 19'd0, "abort_reset");
    exp_st(c + 11, 0, "abort_idle_stall");
    drive(ADD, 1, 0, 0, 0, 0, 19'd2, 19'd3, 19'd0, 5'd3, 0, 0, 0, 0);
    exp_m(c + 12, 1, 0, 0, 0, 5'd3, 19'd3, 19'd5, "abort_accept");
    exp_m(c + 21, 0, 0, 0, 0, 5'd0, 19'd0, 19'd0, "abort_no_result");
    exp_m(c + 22, 0, 0, 0, 0, 5'd0, 19'd0, 19'd0, "abort_no_result2");
    next();
    idle();
    repeat (11) next();
`endif

    idle();
    repeat (3) next();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left, 0 required", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
